// File: rtl/echo_ranger_mc.sv
// Multi-channel HC-SR04 ultrasonic ranger: round-robin trigger, echo timing,
// centimetre conversion and a valid/ready result port.
module echo_ranger_mc #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned TRIG_CYCLES    = 250,
    parameter int unsigned PERIOD_CYCLES  = 1500000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned CM_DIV         = 1450,
    parameter int unsigned DIST_W         = 9,
    localparam int unsigned CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trig,
    output logic              dist_valid,
    input  logic              dist_ready,
    output logic [DIST_W-1:0] dist_data,
    output logic [CHW-1:0]    dist_ch,
    output logic              dist_timeout,
    output logic              busy
);

    localparam int unsigned TRG_W = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PRE_W = $clog2(CM_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        HOLDOFF
    } state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   echo_meta_q;
    logic [NUM_CH-1:0]   echo_sync_q;
    logic [CHW-1:0]      sel_q;
    logic [CHW-1:0]      last_q;
    logic [NUM_CH-1:0]   trig_q;
    logic [TRG_W-1:0]    trig_cnt_q;
    logic [PER_W-1:0]    period_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [PRE_W-1:0]    presc_q;
    logic [DIST_W-1:0]   cm_q;
    logic                dist_valid_q;
    logic [DIST_W-1:0]   dist_data_q;
    logic [CHW-1:0]      dist_ch_q;
    logic                dist_tmo_q;
    logic                busy_q;

    logic [CHW-1:0]      rr_lo;
    logic [CHW-1:0]      rr_hi;
    logic                rr_hi_found;
    logic [CHW-1:0]      rr_sel;
    logic                echo_sel;
    logic                tmo_hit;

    assign trig         = trig_q;
    assign dist_valid   = dist_valid_q;
    assign dist_data    = dist_data_q;
    assign dist_ch      = dist_ch_q;
    assign dist_timeout = dist_tmo_q;
    assign busy         = busy_q;

    assign echo_sel = echo_sync_q[sel_q];
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Round-robin pick: lowest enabled channel above the last served one, else lowest enabled overall
    always_comb begin
        rr_lo       = '0;
        rr_hi       = '0;
        rr_hi_found = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (ch_mask[j]) begin
                rr_lo = CHW'(j);
                if (CHW'(j) > last_q) begin
                    rr_hi       = CHW'(j);
                    rr_hi_found = 1'b1;
                end
            end
        end
        rr_sel = rr_hi_found ? rr_hi : rr_lo;
    end

    // Two-flop synchroniser for the asynchronous echo lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
        end
    end

    // Measurement sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= CHW'(NUM_CH - 1);
            trig_q       <= '0;
            trig_cnt_q   <= '0;
            period_q     <= '0;
            tmo_q        <= '0;
            presc_q      <= '0;
            cm_q         <= '0;
            dist_valid_q <= 1'b0;
            dist_data_q  <= '0;
            dist_ch_q    <= '0;
            dist_tmo_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Trigger-spacing counter runs outside IDLE and saturates
            if (state_q != IDLE && period_q != PER_W'(PERIOD_CYCLES)) begin
                period_q <= period_q + PER_W'(1);
            end

            if (!ena) begin
                state_q      <= IDLE;
                trig_q       <= '0;
                dist_valid_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ch_mask != '0) begin
                            sel_q      <= rr_sel;
                            trig_q     <= NUM_CH'(1) << rr_sel;
                            trig_cnt_q <= '0;
                            period_q   <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= TRIG;
                        end
                    end
                    TRIG: begin
                        if (trig_cnt_q == TRG_W'(TRIG_CYCLES - 1)) begin
                            trig_q  <= '0;
                            tmo_q   <= '0;
                            state_q <= WAIT_RISE;
                        end else begin
                            trig_cnt_q <= trig_cnt_q + TRG_W'(1);
                        end
                    end
                    WAIT_RISE: begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        if (tmo_hit) begin
                            dist_valid_q <= 1'b1;
                            dist_data_q  <= '1;
                            dist_ch_q    <= sel_q;
                            dist_tmo_q   <= 1'b1;
                            state_q      <= REPORT;
                        end else if (echo_sel) begin
                            // The rising cycle itself is the first counted high cycle
                            if (CM_DIV == 1) begin
                                presc_q <= '0;
                                cm_q    <= DIST_W'(1);
                            end else begin
                                presc_q <= PRE_W'(1);
                                cm_q    <= '0;
                            end
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        if (!echo_sel) begin
                            dist_valid_q <= 1'b1;
                            dist_data_q  <= cm_q;
                            dist_ch_q    <= sel_q;
                            dist_tmo_q   <= 1'b0;
                            state_q      <= REPORT;
                        end else if (tmo_hit) begin
                            dist_valid_q <= 1'b1;
                            dist_data_q  <= '1;
                            dist_ch_q    <= sel_q;
                            dist_tmo_q   <= 1'b1;
                            state_q      <= REPORT;
                        end else if (presc_q == PRE_W'(CM_DIV - 1)) begin
                            presc_q <= '0;
                            if (cm_q != '1) begin
                                cm_q <= cm_q + DIST_W'(1);
                            end
                        end else begin
                            presc_q <= presc_q + PRE_W'(1);
                        end
                    end
                    REPORT: begin
                        if (dist_ready) begin
                            dist_valid_q <= 1'b0;
                            last_q       <= sel_q;
                            state_q      <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        if (period_q >= PER_W'(PERIOD_CYCLES)) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        trig_q       <= '0;
                        dist_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_echo_ranger_mc.sv
// Self-checking bench for echo_ranger_mc: directed scenarios plus randomized
// shots compared against a behavioural distance / round-robin model.
module tb_echo_ranger_mc;

    localparam int CM      = 10;
    localparam int TMO     = 200;
    localparam int PERIOD  = 300;
    localparam int TRIGW   = 4;
    localparam int MAX5    = 31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [3:0] echo = 4'b0000;
    logic [3:0] trig;
    logic       dist_valid;
    logic       dist_ready = 1'b1;
    logic [4:0] dist_data;
    logic [1:0] dist_ch;
    logic       dist_timeout;
    logic       busy;

    logic       ena4 = 1'b0;
    logic [3:0] ch_mask4 = 4'b0000;
    logic [3:0] echo4 = 4'b0000;
    logic [3:0] trig4;
    logic       dist_valid4;
    logic       dist_ready4 = 1'b1;
    logic [3:0] dist_data4;
    logic [1:0] dist_ch4;
    logic       dist_timeout4;
    logic       busy4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    echo_ranger_mc #(
        .NUM_CH(4), .TRIG_CYCLES(TRIGW), .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(TMO), .CM_DIV(CM), .DIST_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ch_mask(ch_mask), .echo(echo),
        .trig(trig), .dist_valid(dist_valid), .dist_ready(dist_ready),
        .dist_data(dist_data), .dist_ch(dist_ch), .dist_timeout(dist_timeout),
        .busy(busy)
    );

    echo_ranger_mc #(
        .NUM_CH(4), .TRIG_CYCLES(TRIGW), .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(TMO), .CM_DIV(CM), .DIST_W(4)
    ) dut_w4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .ch_mask(ch_mask4), .echo(echo4),
        .trig(trig4), .dist_valid(dist_valid4), .dist_ready(dist_ready4),
        .dist_data(dist_data4), .dist_ch(dist_ch4), .dist_timeout(dist_timeout4),
        .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference: next channel served after 'last' among set bits of 'm'
    function automatic int rr_next(input logic [3:0] m, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (m[(last + i) % 4]) return (last + i) % 4;
        end
        return last;
    endfunction

    // Reference: centimetres for a pulse of w high cycles, saturated to 'maxv'
    function automatic int ref_dist(input int w, input int maxv);
        int q;
        q = w / CM;
        if (q > maxv) q = maxv;
        return q;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        ena4 = 1'b0;
        echo = '0;
        echo4 = '0;
        dist_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait for a trigger, then drive the selected echo high on cycles [d, d+w) after
    // the trigger falls (cycle 0 = first low cycle); return what the DUT reports.
    task automatic drive_shot(input int d, input int w, input bit noise,
                              input logic [3:0] mask_after,
                              output logic [3:0] trig_v, output int twidth,
                              output int lat, output int start_cyc,
                              output logic [4:0] data_v, output logic [1:0] ch_v,
                              output logic tmo_v);
        int k;
        int ch;
        logic [3:0] en;
        trig_v = '0; twidth = 0; lat = -1; start_cyc = -1;
        data_v = '0; ch_v = '0; tmo_v = 1'b0; ch = 0;
        k = 0;
        while (trig === 4'b0000 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (trig === 4'b0000) return;
        trig_v = trig;
        start_cyc = cyc;
        ch_mask = mask_after;
        for (int j = 3; j >= 0; j--) if (trig_v[j]) ch = j;
        while (trig !== 4'b0000 && twidth < 100) begin
            twidth++;
            @(negedge clk);
        end
        for (int k2 = 0; k2 < 400; k2++) begin
            if (dist_valid === 1'b1) begin
                lat = k2;
                data_v = dist_data;
                ch_v = dist_ch;
                tmo_v = dist_timeout;
                break;
            end
            en = noise ? 4'($urandom) : 4'b0000;
            en[ch] = (k2 >= d && k2 < d + w);
            echo = en;
            @(negedge clk);
        end
        echo = '0;
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({trig, dist_valid, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got trig=%b valid=%b busy=%b, required all 0", trig, dist_valid, busy);
        end
        n_checks++;
        if ({dist_data, dist_ch, dist_timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%0d ch=%0d tmo=%b, required 0/0/0", dist_data, dist_ch, dist_timeout);
        end
        // Asynchronous reset while the trigger is high
        rst_n = 1'b1;
        @(negedge clk);
        ena = 1'b1;
        ch_mask = 4'b0001;
        k = 0;
        while (trig === 4'b0000 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (trig !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_trig: got %b, required 0001", trig);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({trig, busy, dist_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got trig=%b busy=%b valid=%b, required all 0", trig, busy, dist_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] tv; int tw, lat, sc; logic [4:0] dv; logic [1:0] cv; logic tm;
        apply_reset();
        ena = 1'b1;
        ch_mask = 4'b0001;
        drive_shot(3, 57, 1'b0, 4'b0001, tv, tw, lat, sc, dv, cv, tm);
        n_checks++;
        if (tv !== 4'b0001 || tw != TRIGW) begin
            n_fail++;
            $display("FAIL single_trig: got trig=%b width=%0d, required 0001 width %0d", tv, tw, TRIGW);
        end
        n_checks++;
        if (lat < 0 || dv !== 5'(ref_dist(57, MAX5)) || cv !== 2'd0 || tm !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got lat=%0d data=%0d ch=%0d tmo=%b, required data=%0d ch=0 tmo=0",
                     lat, dv, cv, tm, ref_dist(57, MAX5));
        end
        ena = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] tv; int tw, lat, sc; logic [4:0] dv; logic [1:0] cv; logic tm;
        apply_reset();
        ena = 1'b1;
        ch_mask = 4'b0001;
        drive_shot(0, 0, 1'b0, 4'b0001, tv, tw, lat, sc, dv, cv, tm);
        n_checks++;
        if (lat != TMO) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles after trig end, required %0d", lat, TMO);
        end
        n_checks++;
        if (dv !== 5'(MAX5) || tm !== 1'b1 || cv !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_result: got data=%0d tmo=%b ch=%0d, required data=%0d tmo=1 ch=0", dv, tm, cv, MAX5);
        end
        ena = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] tv; int tw, lat, sc, prev_sc, exp_ch, last; logic [4:0] dv; logic [1:0] cv; logic tm;
        apply_reset();
        ena = 1'b1;
        ch_mask = 4'b1010;
        last = 3;
        prev_sc = -1;
        for (int s = 0; s < 3; s++) begin
            exp_ch = rr_next(4'b1010, last);
            drive_shot(5, 20, 1'b1, 4'b1010, tv, tw, lat, sc, dv, cv, tm);
            n_checks++;
            if (tv !== (4'b0001 << exp_ch) || cv !== 2'(exp_ch)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got trig=%b ch=%0d, required ch %0d", s, tv, cv, exp_ch);
            end
            n_checks++;
            if (lat < 0 || dv !== 5'(ref_dist(20, MAX5)) || tm !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_data[%0d]: got data=%0d tmo=%b, required %0d tmo=0", s, dv, tm, ref_dist(20, MAX5));
            end
            if (s > 0) begin
                n_checks++;
                if (sc - prev_sc < PERIOD) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, required >= %0d", s, sc - prev_sc, PERIOD);
                end
            end
            prev_sc = sc;
            last = exp_ch;
        end
        ena = 1'b0;
    endtask

    task automatic test_saturation();
        int k;
        apply_reset();
        ena4 = 1'b1;
        ch_mask4 = 4'b0001;
        k = 0;
        while (trig4 === 4'b0000 && k < 50) begin @(negedge clk); k++; end
        while (trig4 !== 4'b0000 && k < 100) begin @(negedge clk); k++; end
        echo4 = 4'b0001;
        repeat (180) @(negedge clk);
        echo4 = 4'b0000;
        k = 0;
        while (dist_valid4 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        n_checks++;
        if (dist_valid4 !== 1'b1 || dist_data4 !== 4'(ref_dist(180, 15)) || dist_timeout4 !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation: got valid=%b data=%0d tmo=%b, required valid=1 data=%0d tmo=0",
                     dist_valid4, dist_data4, dist_timeout4, ref_dist(180, 15));
        end
        ena4 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] tv; int tw, lat, sc, k; logic [4:0] dv; logic [1:0] cv; logic tm;
        logic stable, dv1;
        apply_reset();
        ena = 1'b1;
        ch_mask = 4'b0001;
        dist_ready = 1'b0;
        drive_shot(2, 30, 1'b0, 4'b0001, tv, tw, lat, sc, dv, cv, tm);
        n_checks++;
        if (lat < 0 || dv !== 5'(ref_dist(30, MAX5)) || tm !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d data=%0d tmo=%b, required data=%0d tmo=0", lat, dv, tm, ref_dist(30, MAX5));
        end
        stable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (dist_valid !== 1'b1 || dist_data !== dv || dist_ch !== cv || dist_timeout !== tm || trig !== 4'b0000)
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got unstable result or trig during stall, required held result and no trig");
        end
        dist_ready = 1'b1;
        dv1 = 1'b1;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) dv1 = dist_valid;
            if (trig !== 4'b0000) begin k = i; break; end
        end
        n_checks++;
        if (dv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_valid_drop: got valid=%b after accept, required 0", dv1);
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL bp_retrig: got trig at negedge %0d after ready, required 3 (2 cycles after accept)", k);
        end
        ena = 1'b0;
    endtask

    task automatic test_abort();
        logic [3:0] tv; int tw, lat, sc, k; logic [4:0] dv; logic [1:0] cv; logic tm;
        logic quiet;
        apply_reset();
        ena = 1'b1;
        ch_mask = 4'b1010;
        k = 0;
        while (trig === 4'b0000 && k < 50) begin @(negedge clk); k++; end
        n_checks++;
        if (trig !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_first: got trig=%b, required 0010", trig);
        end
        while (trig !== 4'b0000 && k < 100) begin @(negedge clk); k++; end
        echo = 4'b0010;
        repeat (15) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dist_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b valid=%b, required 0/0", busy, dist_valid);
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dist_valid !== 1'b0 || trig !== 4'b0000 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity while disabled, required none");
        end
        echo = 4'b0000;
        ena = 1'b1;
        drive_shot(3, 20, 1'b0, 4'b1010, tv, tw, lat, sc, dv, cv, tm);
        n_checks++;
        if (tv !== 4'b0010 || cv !== 2'd1 || dv !== 5'(ref_dist(20, MAX5))) begin
            n_fail++;
            $display("FAIL abort_retrig: got trig=%b ch=%0d data=%0d, required 0010 ch=1 data=%0d", tv, cv, dv, ref_dist(20, MAX5));
        end
        ena = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] tv, m, m2; int tw, lat, sc, d, w, kind, exp_ch, last, exp_d;
        logic [4:0] dv; logic [1:0] cv; logic tm; logic exp_t;
        apply_reset();
        last = 3;
        do m = 4'($urandom); while (m == 4'b0000);
        ch_mask = m;
        ena = 1'b1;
        for (int s = 0; s < 8; s++) begin
            do m2 = 4'($urandom); while (m2 == 4'b0000);
            kind = int'($urandom_range(3, 0));
            d = int'($urandom_range(60, 0));
            if (kind == 0) w = 0;
            else if (kind == 1) w = 200 + int'($urandom_range(49, 0));
            else w = 1 + int'($urandom_range(109, 0));
            exp_t = (w == 0 || d + 2 + w > TMO - 1);
            exp_d = exp_t ? MAX5 : ref_dist(w, MAX5);
            exp_ch = rr_next(m, last);
            drive_shot(d, w, 1'b1, m2, tv, tw, lat, sc, dv, cv, tm);
            n_checks++;
            if (tv !== (4'b0001 << exp_ch) || tw != TRIGW) begin
                n_fail++;
                $display("FAIL rand_trig[%0d]: got trig=%b width=%0d, required ch %0d width %0d", s, tv, tw, exp_ch, TRIGW);
            end
            n_checks++;
            if (cv !== 2'(exp_ch)) begin
                n_fail++;
                $display("FAIL rand_ch[%0d]: got %0d, required %0d", s, cv, exp_ch);
            end
            n_checks++;
            if (lat < 0 || dv !== 5'(exp_d)) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %0d (lat %0d), required %0d (d=%0d w=%0d)", s, dv, lat, exp_d, d, w);
            end
            n_checks++;
            if (tm !== exp_t) begin
                n_fail++;
                $display("FAIL rand_tmo[%0d]: got %b, required %b (d=%0d w=%0d)", s, tm, exp_t, d, w);
            end
            last = exp_ch;
            m = m2;
        end
        ena = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_ranger_mc.md
ECHO_RANGER_MC -- requirements
Module: echo_ranger_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4 (1..8): number of HC-SR04 channels.
REQ-002 SHALL have parameter TRIG_CYCLES, default 250: trigger pulse width in clk cycles (10 us at 25 MHz).
REQ-003 SHALL have parameter PERIOD_CYCLES, default 1500000: minimum spacing between successive trigger starts (60 ms).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum cycles from trigger end to echo fall (30 ms).
REQ-005 SHALL have parameter CM_DIV, default 1450: clk cycles per reported centimetre (58 us at 25 MHz).
REQ-006 SHALL have parameter DIST_W, default 9: distance width; CHW = max(1, clog2(NUM_CH)).
REQ-007 clk  input  1  system clock, all logic rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 ena  input  1  run enable.
REQ-010 ch_mask  input  NUM_CH  per-channel enable, sampled only in IDLE.
REQ-011 echo  input  NUM_CH  raw sensor echo lines, asynchronous.
REQ-012 trig  output  NUM_CH  sensor trigger lines, registered.
REQ-013 dist_valid  output  1  result available.
REQ-014 dist_ready  input  1  consumer accepts result.
REQ-015 dist_data  output  DIST_W  distance in cm.
REQ-016 dist_ch  output  CHW  channel index of result.
REQ-017 dist_timeout  output  1  result is a timeout.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 Each echo bit SHALL pass a 2-flop synchroniser; all echo decisions use synchronised values (2-cycle latency).
REQ-020 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF.
REQ-021 IDLE: ena=1 and ch_mask!=0 -> select first set mask bit after last-served channel (round-robin, wraps NUM_CH-1 -> 0; first after reset searches from ch0) -> TRIG; mask==0 -> stay IDLE.
REQ-022 TRIG: trig[sel] high exactly TRIG_CYCLES cycles, other trig bits low; period counter starts from 0 on TRIG entry; then -> WAIT_RISE with timeout counter cleared.
REQ-023 WAIT_RISE: synchronised echo[sel] high -> MEASURE; timeout counter reaching TIMEOUT_CYCLES first -> REPORT as timeout.
REQ-024 MEASURE: prescaler counts clk; every CM_DIV high cycles cm counter increments, saturating at 2^DIST_W-1; echo[sel] low -> REPORT with dist_data = floor(high_cycles/CM_DIV) saturated, dist_timeout=0.
REQ-025 Timeout counter SHALL keep running through MEASURE; reaching TIMEOUT_CYCLES in MEASURE -> REPORT as timeout.
REQ-026 Timeout result: dist_data = all ones, dist_timeout=1.
REQ-027 REPORT: dist_valid=1, dist_data/dist_ch/dist_timeout stable until accepted; transfer when dist_valid & dist_ready at rising edge; then -> HOLDOFF, dist_valid=0 next cycle.
REQ-028 HOLDOFF: wait until period counter >= PERIOD_CYCLES, then -> IDLE; if already elapsed on entry, leave next cycle. Period counter saturates, never wraps.
REQ-029 Echo activity on non-selected channels SHALL be ignored.
REQ-030 ch_mask changes outside IDLE SHALL not affect the in-progress measurement.
REQ-031 ena=0 in any state SHALL abort to IDLE next cycle: trig=0, dist_valid=0, no result issued, last-served channel unchanged.
REQ-032 Counter widths SHALL hold their parameter maxima without overflow.

Reset
REQ-033 On rst_n low: state IDLE, trig=0, dist_valid=0, dist_data=0, dist_ch=0, dist_timeout=0, busy=0, all counters and synchronisers 0, round-robin pointer so ch0 is served first.
REQ-034 Reset assertion mid-operation SHALL immediately force the above values, including trig.

Verification (NUM_CH=4, TRIG_CYCLES=4, CM_DIV=10, TIMEOUT_CYCLES=200, PERIOD_CYCLES=300, DIST_W=5 unless stated)
REQ-035 Reset then ena=1, mask=4'b0001, echo[0] high 57 synchronised cycles -> trig[0] high 4 cycles; dist_valid with dist_data=5, dist_ch=0, dist_timeout=0.
REQ-036 mask=4'b0001, echo never rises -> dist_valid 200 cycles after trig end, dist_data=31, dist_timeout=1.
REQ-037 mask=4'b1010, ready=1, echo pulses 20 cycles -> trig order ch1, ch3, ch1; trig starts >= 300 cycles apart; each dist_data=2.
REQ-038 DIST_W=4 variant, echo high 180 cycles -> dist_data=15 (saturated), dist_timeout=0.
REQ-039 dist_ready low 500 cycles during REPORT -> dist_valid and data held stable, no trig pulse; after ready=1 accept, next trig starts 2 cycles later.
REQ-040 ena dropped in MEASURE -> busy=0 next cycle, no dist_valid; ena restored -> same channel retriggered.
